// File: rtl/vip_video_stream_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_pkg
//  Description : Shared definitions for the VIP video stream generator:
//                test-pattern encodings, FSM state encoding, pixel width,
//                flat-pattern value and checker cell size.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        PAT_FRAME_RAMP = 2'd0,
        PAT_HRAMP      = 2'd1,
        PAT_CHECKER    = 2'd2,
        PAT_FLAT       = 2'd3
    } pattern_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    localparam logic [PIX_W-1:0] FLAT_VALUE   = 8'h80;
    localparam int               CHECKER_SIZE = 8;
    // Coordinate bit that toggles every CHECKER_SIZE pixels.
    localparam int               CHECKER_BIT  = $clog2(CHECKER_SIZE);

endpackage
`default_nettype wire

// File: rtl/vip_video_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vip_video_stream_gen_if
//  Description : Video stream bundle produced by the generator and consumed
//                by the 3x3 matrix generator / VIP filters.
//  Signals     : per_frame_vsync, per_frame_href, per_frame_hsync,
//                per_img_Y[7:0], frame_done, busy
//  Modports    : master (generator side), slave (consumer side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vip_video_stream_gen_if;
    import vip_pkg::*;

    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_hsync;
    logic [PIX_W-1:0] per_img_Y;
    logic             frame_done;
    logic             busy;

    modport master (
        output per_frame_vsync,
        output per_frame_href,
        output per_frame_hsync,
        output per_img_Y,
        output frame_done,
        output busy
    );

    modport slave (
        input per_frame_vsync,
        input per_frame_href,
        input per_frame_hsync,
        input per_img_Y,
        input frame_done,
        input busy
    );
endinterface
`default_nettype wire

// File: rtl/vip_video_stream_gen_timing_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vip_timing_counter
//  Description : Horizontal/vertical raster counters with frame-end strobe
//                and combinational sync / active-window decode.
//  Ports       : clk, rst_n      - pixel clock, async active-low reset
//                advance         - 1: counters run, 0: counters held at 0
//                frame_end       - counters at last clock of the frame
//                hsync, vsync    - sync decode of current counter values
//                active          - counters inside the active window
//                x_lo            - low 8 bits of active-window x
//                checker_cell    - x[3] XOR y[3] of active-window coords
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_timing_counter
    import vip_pkg::*;
#(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 220,
    parameter int H_FRONT   = 110,
    parameter int V_SYNC    = 5,
    parameter int V_BACK    = 20,
    parameter int V_FRONT   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic             frame_end,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [PIX_W-1:0] x_lo,
    output logic             checker_cell
);

    localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    // Decode compares run one bit wider so that window ends equal to the
    // total never overflow the counter width.
    localparam int H_W1    = H_W + 1;
    localparam int V_W1    = V_W + 1;

    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [H_W1-1:0] H_SYNC_END = H_W1'(H_SYNC);
    localparam logic [V_W1-1:0] V_SYNC_END = V_W1'(V_SYNC);
    localparam logic [H_W1-1:0] H_ACT_BEG  = H_W1'(H_SYNC + H_BACK);
    localparam logic [H_W1-1:0] H_ACT_END  = H_W1'(H_SYNC + H_BACK + IMG_HDISP);
    localparam logic [V_W1-1:0] V_ACT_BEG  = V_W1'(V_SYNC + V_BACK);
    localparam logic [V_W1-1:0] V_ACT_END  = V_W1'(V_SYNC + V_BACK + IMG_VDISP);

    logic [H_W-1:0]  r_h_cnt;
    logic [V_W-1:0]  r_v_cnt;
    logic [H_W1-1:0] w_h_ext;
    logic [V_W1-1:0] w_v_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!advance) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_h_ext   = {1'b0, r_h_cnt};
    assign w_v_ext   = {1'b0, r_v_cnt};

    assign frame_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign hsync     = (w_h_ext < H_SYNC_END);
    assign vsync     = (w_v_ext < V_SYNC_END);
    assign active    = (w_h_ext >= H_ACT_BEG) && (w_h_ext < H_ACT_END) &&
                       (w_v_ext >= V_ACT_BEG) && (w_v_ext < V_ACT_END);

    // Coordinates are only meaningful while active is high; outside the
    // window the subtraction simply wraps and is masked by the consumer.
    assign x_lo         = PIX_W'(w_h_ext - H_ACT_BEG);
    assign checker_cell = 1'((w_h_ext - H_ACT_BEG) >> CHECKER_BIT) ^
                          1'((w_v_ext - V_ACT_BEG) >> CHECKER_BIT);

endmodule
`default_nettype wire

// File: rtl/vip_video_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vip_video_stream_gen
//  Description : Parameterised video stream transmitter producing
//                vsync/href/hsync and an 8-bit Y test pattern.
//  Ports       : clk         - pixel clock
//                rst_n       - asynchronous active-low reset
//                enable      - level; 1 = generate frames continuously
//                pattern_sel - 0 frame ramp, 1 h-ramp, 2 8x8 checker, 3 flat
//                vid         - video stream bundle (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_video_stream_gen
    import vip_pkg::*;
#(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 220,
    parameter int H_FRONT   = 110,
    parameter int V_SYNC    = 5,
    parameter int V_BACK    = 20,
    parameter int V_FRONT   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [1:0]             pattern_sel,
    vip_video_stream_gen_if.master vid
);

    gen_state_t       r_state;
    pattern_t         r_pattern;
    logic [PIX_W-1:0] r_pix_idx;

    logic             r_vsync;
    logic             r_hsync;
    logic             r_href;
    logic [PIX_W-1:0] r_y;
    logic             r_frame_done;
    logic             r_busy;

    logic             w_advance;
    logic             w_frame_end;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_active;
    logic [PIX_W-1:0] w_x_lo;
    logic             w_checker_cell;
    logic [PIX_W-1:0] w_pixel;

    assign w_advance = (r_state == ST_RUN);

    vip_timing_counter #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .H_FRONT   (H_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .V_FRONT   (V_FRONT)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance      (w_advance),
        .frame_end    (w_frame_end),
        .hsync        (w_hsync),
        .vsync        (w_vsync),
        .active       (w_active),
        .x_lo         (w_x_lo),
        .checker_cell (w_checker_cell)
    );

    // Pattern value for the current counter position. The frame ramp uses a
    // running count of active pixels, which equals y*IMG_HDISP + x modulo 256
    // because the window is scanned in raster order.
    always_comb begin
        w_pixel = '0;
        if (w_active) begin
            case (r_pattern)
                PAT_FRAME_RAMP: w_pixel = r_pix_idx;
                PAT_HRAMP:      w_pixel = w_x_lo;
                PAT_CHECKER:    w_pixel = w_checker_cell ? 8'hFF : 8'h00;
                PAT_FLAT:       w_pixel = FLAT_VALUE;
                default:        w_pixel = '0;
            endcase
        end
    end

    // FSM plus output registers. Outputs lag the counters by one clock, so
    // the frame_done pulse lines up with the last frame clock on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pattern    <= PAT_FRAME_RAMP;
            r_pix_idx    <= '0;
            r_vsync      <= 1'b0;
            r_hsync      <= 1'b0;
            r_href       <= 1'b0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_vsync      <= 1'b0;
            r_hsync      <= 1'b0;
            r_href       <= 1'b0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= (r_state == ST_RUN);

            case (r_state)
                ST_IDLE: begin
                    r_pix_idx <= '0;
                    if (enable) begin
                        r_state   <= ST_RUN;
                        r_pattern <= pattern_t'(pattern_sel);
                    end
                end
                ST_RUN: begin
                    r_vsync <= w_vsync;
                    r_hsync <= w_hsync;
                    r_href  <= w_active;
                    r_y     <= w_pixel;
                    if (w_frame_end) begin
                        // Frame boundary: the only point where the pattern
                        // may change or the generator may stop.
                        r_frame_done <= 1'b1;
                        r_pix_idx    <= '0;
                        if (enable) begin
                            r_pattern <= pattern_t'(pattern_sel);
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end else if (w_active) begin
                        r_pix_idx <= r_pix_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign vid.per_frame_vsync = r_vsync;
    assign vid.per_frame_href  = r_href;
    assign vid.per_frame_hsync = r_hsync;
    assign vid.per_img_Y       = r_y;
    assign vid.frame_done      = r_frame_done;
    assign vid.busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vip_video_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vip_video_stream_gen
//  Description : Self-checking bench for vip_video_stream_gen. Expected
//                pixels are queued per frame from a reference pattern
//                function; monitors pop them on href and check raster timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_video_stream_gen;

    localparam int A_HD = 8;
    localparam int A_VD = 4;
    localparam int B_HD = 16;
    localparam int B_VD = 16;
    localparam int H_TOT = 14;
    localparam int FRAME = 98;

    logic       clk;
    logic       rst_n;
    logic       en_a, en_b;
    logic [1:0] ps_a, ps_b;

    vip_video_stream_gen_if vid_a ();
    vip_video_stream_gen_if vid_b ();

    vip_video_stream_gen #(
        .IMG_HDISP(A_HD), .IMG_VDISP(A_VD), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(ps_a), .vid(vid_a)
    );

    vip_video_stream_gen #(
        .IMG_HDISP(B_HD), .IMG_VDISP(B_VD), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(ps_b), .vid(vid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rel    = 0;
    int frames_a = 0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: pixel %0d with no expected pixel queued (t=%0t)", name, act, $time);
    endtask

    // Reference pattern computed directly from frame coordinates.
    function automatic logic [7:0] ref_pix(input int pat, input int x, input int y, input int hd);
        case (pat)
            0:       return 8'((y * hd + x) % 256);
            1:       return 8'(x % 256);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    task automatic push_a(input int pat);
        for (int y = 0; y < A_VD; y++)
            for (int x = 0; x < A_HD; x++)
                exp_a.push_back(ref_pix(pat, x, y, A_HD));
    endtask

    task automatic push_b(input int pat);
        for (int y = 0; y < B_VD; y++)
            for (int x = 0; x < B_HD; x++)
                exp_b.push_back(ref_pix(pat, x, y, B_HD));
    endtask

    task automatic goto_rel(input int t);
        while (rel < t) begin
            @(negedge clk);
            rel++;
        end
    endtask

    // Returns clocks from the current sample to the first href sample.
    task automatic measure_latency(output int n);
        n = 0;
        while (!vid_a.per_frame_href && n < 200) begin
            @(negedge clk);
            n++;
        end
        rel += n;
    endtask

    task automatic wait_fd_a(input int bound);
        int n = 0;
        while (!vid_a.frame_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_a_seen", int'(vid_a.frame_done), 1);
    endtask

    task automatic chk_all_zero_a(input string name);
        chk({name, "_vsync"}, int'(vid_a.per_frame_vsync), 0);
        chk({name, "_href"},  int'(vid_a.per_frame_href), 0);
        chk({name, "_hsync"}, int'(vid_a.per_frame_hsync), 0);
        chk({name, "_Y"},     int'(vid_a.per_img_Y), 0);
        chk({name, "_fdone"}, int'(vid_a.frame_done), 0);
        chk({name, "_busy"},  int'(vid_a.busy), 0);
    endtask

    // ---------------- Monitor A: pixels and raster timing ----------------
    int   mcyc = 0;
    int   hs_len, vs_len, last_rise, href_cnt;
    logic prev_vs, prev_fd, prev_en;

    always @(negedge clk) begin
        mcyc++;
        if (!rst_n) begin
            hs_len = 0; vs_len = 0; last_rise = -1; href_cnt = 0;
            prev_vs = 1'b0; prev_fd = 1'b0; prev_en = 1'b0;
        end else begin
            if (vid_a.per_frame_href) begin
                href_cnt++;
                if (exp_a.size() == 0) unexpected("pix_a", int'(vid_a.per_img_Y));
                else chk("pix_a", int'(vid_a.per_img_Y), int'(exp_a.pop_front()));
            end else begin
                chk("blank_Y_a", int'(vid_a.per_img_Y), 0);
            end

            if (vid_a.per_frame_hsync) hs_len++;
            else if (hs_len != 0) begin chk("hsync_width", hs_len, 2); hs_len = 0; end

            if (vid_a.per_frame_vsync) vs_len++;
            else if (vs_len != 0) begin chk("vsync_width", vs_len, H_TOT); vs_len = 0; end

            if (vid_a.per_frame_vsync && !prev_vs) begin
                if (prev_fd && last_rise >= 0) chk("vsync_spacing", mcyc - last_rise, FRAME);
                last_rise = mcyc;
            end

            if (prev_fd) begin
                chk("frame_done_pulse", int'(vid_a.frame_done), 0);
                chk("after_fd_vsync", int'(vid_a.per_frame_vsync), int'(prev_en));
                chk("after_fd_busy", int'(vid_a.busy), int'(prev_en));
            end

            if (vid_a.frame_done) begin
                chk("frame_href_count", href_cnt, A_HD * A_VD);
                if (last_rise >= 0) chk("frame_done_pos", mcyc - last_rise, FRAME - 1);
                href_cnt = 0;
                frames_a++;
            end

            prev_vs = vid_a.per_frame_vsync;
            prev_fd = vid_a.frame_done;
            prev_en = en_a;
        end
    end

    // ---------------- Monitor B: checker pixels ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (vid_b.per_frame_href) begin
                if (exp_b.size() == 0) unexpected("pix_b", int'(vid_b.per_img_Y));
                else chk("pix_b", int'(vid_b.per_img_Y), int'(exp_b.pop_front()));
            end else if (vid_b.per_img_Y != 8'h00) begin
                chk("blank_Y_b", int'(vid_b.per_img_Y), 0);
            end
        end
    end

    // ---------------- Stimulus ----------------
    int pats [6];
    int lat;
    int p;

    initial begin
        rst_n = 1'b0; en_a = 1'b0; ps_a = 2'd0; en_b = 1'b0; ps_b = 2'd0;
        repeat (3) @(negedge clk);
        chk_all_zero_a("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero_a("idle");

        pats[0] = 0;
        pats[1] = int'($urandom_range(0, 3));
        pats[2] = 1;
        pats[3] = 3;
        pats[4] = int'($urandom_range(0, 3));
        pats[5] = int'($urandom_range(0, 3));

        // Run six back-to-back frames; the last one is stopped at line 3.
        ps_a = 2'd0; en_a = 1'b1; push_a(0);
        @(negedge clk); rel = 0;
        measure_latency(lat);
        chk("first_href_latency", lat, 33);
        for (int k = 0; k < 6; k++) begin
            goto_rel(k * FRAME + 20);
            ps_a = (k == 2) ? 2'd3 : 2'($urandom_range(0, 3));
            if (k == 1) begin
                en_a = 1'b0;
                goto_rel(k * FRAME + 35);
                en_a = 1'b1;
            end
            if (k == 5) begin
                goto_rel(k * FRAME + 3 * H_TOT + 5);
                en_a = 1'b0;
            end
            goto_rel(k * FRAME + 50);
            if (k < 5) begin
                ps_a = 2'(pats[k + 1]);
                push_a(pats[k + 1]);
            end
        end
        goto_rel(6 * FRAME + 10);
        chk("frames_completed", frames_a, 6);
        chk("queue_a_drained", exp_a.size(), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stopped_outputs", int'({vid_a.per_frame_vsync, vid_a.per_frame_href,
                vid_a.per_frame_hsync, vid_a.frame_done, vid_a.busy}) + int'(vid_a.per_img_Y), 0);
        end

        // Asynchronous reset during active pixels, then a fresh frame.
        p = int'($urandom_range(0, 3));
        ps_a = 2'(p); en_a = 1'b1; push_a(p);
        @(negedge clk); rel = 0;
        goto_rel(36);
        chk("href_before_reset", int'(vid_a.per_frame_href), 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero_a("async_reset");
        exp_a.delete();
        repeat (2) @(negedge clk);
        p = int'($urandom_range(0, 3));
        ps_a = 2'(p); push_a(p);
        rst_n = 1'b1;
        @(negedge clk); rel = 0;
        measure_latency(lat);
        chk("restart_href_latency", lat, 33);
        goto_rel(3 * H_TOT + 5);
        en_a = 1'b0;
        wait_fd_a(200);
        repeat (5) @(negedge clk);
        chk("queue_a_after_restart", exp_a.size(), 0);
        chk("busy_after_restart", int'(vid_a.busy), 0);

        // Checker pattern on the 16x16 instance, single frame.
        ps_b = 2'd2; en_b = 1'b1; push_b(2);
        repeat (20) @(negedge clk);
        ps_b = 2'd1;
        en_b = 1'b0;
        begin
            int n = 0;
            while (!vid_b.frame_done && n < 1000) begin
                @(negedge clk);
                n++;
            end
            chk("frame_done_b_seen", int'(vid_b.frame_done), 1);
        end
        repeat (3) @(negedge clk);
        chk("queue_b_drained", exp_b.size(), 0);
        chk("busy_b_stopped", int'(vid_b.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/vip_video_stream_gen.md
Name: vip_video_stream_gen

Overview:
Synthesizable video stream transmitter for the ISP path. It produces the per_frame_vsync/href/hsync plus 8-bit Y stream that the 3x3 matrix generator and the downstream VIP filters consume.
- Frame geometry and blanking are set by parameters; the test pattern is selectable.
- Used as the on-chip source for bring-up and as the stimulus driver in block-level benches, in place of ad-hoc behavioural drivers.

Parameters:
IMG_HDISP, 1280, active pixels per line
IMG_VDISP, 720, active lines per frame
H_SYNC, 40, hsync pulse width in clocks
H_BACK, 220, clocks from end of hsync to first active pixel
H_FRONT, 110, clocks from last active pixel to next hsync
V_SYNC, 5, vsync width in lines
V_BACK, 20, lines from end of vsync to first active line
V_FRONT, 5, lines from last active line to next vsync

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = generate frames continuously
pattern_sel  in  2  0 = frame ramp, 1 = horizontal ramp, 2 = 8x8 checker, 3 = flat 0x80
per_frame_vsync  out  1  vsync, active high
per_frame_href  out  1  active-pixel qualifier
per_frame_hsync  out  1  hsync, active high
per_img_Y  out  8  pixel luma; 0 when href is low
frame_done  out  1  one-clock pulse on the last clock of each frame
busy  out  1  1 while a frame is in progress

Behaviour:
- Reset: all outputs 0, FSM IDLE, h_cnt = v_cnt = 0, latched pattern = 0. Reset asserted mid-frame aborts the frame immediately; no partial-frame completion.
- Derived constants: H_TOTAL = H_SYNC+H_BACK+IMG_HDISP+H_FRONT; V_TOTAL = V_SYNC+V_BACK+IMG_VDISP+V_FRONT.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps; v_cnt counts 0..V_TOTAL-1.
  - Counter widths are $clog2 of the totals.
- FSM:
  - IDLE: counters held at 0, outputs 0. Go to RUN when enable = 1, latching pattern_sel at the same clock.
  - RUN: counters advance every clock. At h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1 (frame end):
    - enable = 1: stay in RUN, wrap to 0/0, re-latch pattern_sel.
    - enable = 0: go to IDLE.
  - Deasserting enable mid-frame never truncates a frame. Reasserting it before frame end causes no gap.
- Decode, evaluated on counter values and registered, giving 1 clock latency from counters to outputs:
  - hsync = (h_cnt < H_SYNC).
  - vsync = (v_cnt < V_SYNC).
  - x = h_cnt - (H_SYNC+H_BACK); y = v_cnt - (V_SYNC+V_BACK).
  - href = 0 <= x < IMG_HDISP and 0 <= y < IMG_VDISP.
  - In IDLE, hsync, vsync and href are all 0.
- Pattern, computed only when href = 1; Y = 0 otherwise:
  - 0 (frame ramp): (y*IMG_HDISP + x) mod 256. Keep a running 8-bit pixel index reset at the frame start; no multiplier.
  - 1 (horizontal ramp): x[7:0].
  - 2 (8x8 checker): 0xFF if x[3] XOR y[3], else 0x00.
  - 3 (flat): 0x80.
- pattern_sel changes mid-frame are ignored until the next frame start.
- frame_done: registered, so it rises together with the outputs for the last frame clock. It fires in both the continue and stop cases.
- busy: 1 in RUN, 0 in IDLE (registered, aligned with the outputs).
- Output spacing: back-to-back frames have exactly H_TOTAL*V_TOTAL clocks between successive vsync rising edges.

Decomposition:
- Shared package vip_pkg holds:
  - pattern encodings (PAT_FRAME_RAMP = 0, PAT_HRAMP = 1, PAT_CHECKER = 2, PAT_FLAT = 3);
  - FSM state encoding;
  - flat value 0x80 and checker size 8.
- One natural sub-module: vip_timing_counter. It holds h_cnt/v_cnt, the frame-end strobe, and the active-window decode. The top level holds the FSM, pattern logic and output registers.

Test Plan:
Use IMG_HDISP=8, IMG_VDISP=4, H_SYNC=2, H_BACK=2, H_FRONT=2, V_SYNC=1, V_BACK=1, V_FRONT=1, giving H_TOTAL = 14, V_TOTAL = 7 and 98 clocks per frame.
1. Reset then enable = 1 with pattern 0 -> outputs 0 during reset. The first href rises 1+2*14+4 = 33 clocks after the RUN entry clock. Y values are 0..7 on line 0 and 8..15 on line 1, through 31. vsync is high exactly 14 clocks; each hsync is 2 clocks high.
2. Continuous run -> vsync rising edges exactly 98 clocks apart. frame_done pulses once per frame on the clock before the next vsync.
3. Pattern 2 with IMG_HDISP = 16, IMG_VDISP = 16 -> Y = 0x00 for x 0..7 on rows 0..7 and 0xFF for x 8..15. The pattern inverts on rows 8..15.
4. Change pattern_sel from 1 to 3 mid-frame -> the current frame keeps the ramp. The next frame is all 0x80 during href, and Y = 0 outside href.
5. Drop enable at line 3 of a frame -> the frame completes fully (32 href clocks total), frame_done pulses, then busy = 0 and all outputs stay 0.
6. Assert rst_n = 0 during active pixels -> all outputs go to 0 immediately (asynchronously). After release with enable = 1, a fresh frame starts from h = v = 0.
